// File: rtl/fb_scanout_if.sv
`default_nettype none
// ============================================================================
// fb_scanout_if : SRAM read port between the scanout engine and the arbiter
// Revision      : 1.0
// ============================================================================
interface fb_scanout_if;
  logic        sram_req;
  logic [19:0] sram_addr;
  logic        sram_gnt;
  logic [15:0] sram_rdata;

  modport master (
    output sram_req,
    output sram_addr,
    input  sram_gnt,
    input  sram_rdata
  );

  modport slave (
    input  sram_req,
    input  sram_addr,
    output sram_gnt,
    output sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// fb_scanout : double-buffered framebuffer row fetch and 2x pixel scanout
// Revision   : 1.0
// ============================================================================
module fb_scanout #(
  parameter int H_SRC = 320,
  parameter int V_SRC = 240
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       line_start,
  input  wire logic [9:0] src_row,
  fb_scanout_if.master    sram,
  input  wire logic       pix_en,
  input  wire logic [9:0] pix_x,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b,
  output logic            busy,
  output logic            underrun
);

  localparam int          C_AW       = (H_SRC > 1) ? $clog2(H_SRC) : 1;
  localparam logic [9:0]  C_LAST_COL = 10'(H_SRC - 1);
  localparam logic [9:0]  C_H_LIM    = 10'(H_SRC);
  localparam logic [10:0] C_V_LIM    = 11'(V_SRC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [9:0]        r_col;
  logic [9:0]        r_row;
  logic              r_ready;
  logic              r_front_valid;
  logic              r_front_sel;
  logic              r_underrun;
  logic              r_rd_vld;
  logic [C_AW-1:0]   r_rd_col;
  logic [11:0]       r_buf0 [H_SRC];
  logic [11:0]       r_buf1 [H_SRC];

  logic              w_ls_ok;
  logic              w_issue;
  logic              w_wr_en;
  logic              w_pcol_ok;
  logic [C_AW-1:0]   w_pidx;
  logic [11:0]       w_front_px;
  logic              w_unused;

  assign w_ls_ok   = line_start && ({1'b0, src_row} < C_V_LIM);
  assign busy      = (r_state != S_IDLE);
  assign underrun  = r_underrun;
  // A line_start while busy aborts the fetch, so the word landing that cycle is dropped too.
  assign w_wr_en   = r_rd_vld && !w_ls_ok && !rst;
  assign w_pidx    = pix_x[C_AW:1];
  assign w_pcol_ok = ({1'b0, pix_x[9:1]} < C_H_LIM);
  assign w_unused  = ^{sram.sram_rdata[3:0], pix_x[0]};

  always_comb begin
    w_state_nxt    = r_state;
    w_issue        = 1'b0;
    sram.sram_req  = 1'b0;
    sram.sram_addr = '0;
    case (r_state)
      S_FETCH: begin
        sram.sram_req  = 1'b1;
        sram.sram_addr = {r_col, r_row};
        w_issue        = sram.sram_gnt;
        if (sram.sram_gnt && (r_col == C_LAST_COL)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_ls_ok) begin
      w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_ready       <= 1'b0;
      r_front_valid <= 1'b0;
      r_front_sel   <= 1'b0;
      r_underrun    <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_rd_col      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= w_issue && !w_ls_ok;
      r_rd_col <= r_col[C_AW-1:0];
      if (w_ls_ok) begin
        r_col <= '0;
        r_row <= src_row;
        if (busy) begin
          r_underrun <= 1'b1;
        end else if (r_ready) begin
          r_front_sel   <= ~r_front_sel;
          r_front_valid <= 1'b1;
          r_ready       <= 1'b0;
        end
      end else begin
        if (w_issue) begin
          r_col <= r_col + 10'd1;
        end
        if (r_state == S_DRAIN) begin
          r_ready <= 1'b1;
        end
      end
    end
  end

  // r_front_sel=0 displays buf0 and fills buf1; the swap only flips this bit.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_front_sel) begin
        r_buf0[r_rd_col] <= sram.sram_rdata[15:4];
      end else begin
        r_buf1[r_rd_col] <= sram.sram_rdata[15:4];
      end
    end
  end

  assign w_front_px = r_front_sel ? r_buf1[w_pidx] : r_buf0[w_pidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pix_en && w_pcol_ok && r_front_valid) begin
      vga_r <= {w_front_px[11:8], 4'h0};
      vga_g <= {w_front_px[7:4],  4'h0};
      vga_b <= {w_front_px[3:0],  4'h0};
    end else begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter H_SRC, default 320, source pixels per framebuffer row.
REQ-002 Parameter V_SRC, default 240, source rows per frame.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  pixel-rate clock (vga_ctrl_clk domain), all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 line_start  in  1  one-cycle pulse: present fetched row to display, begin fetching src_row.
REQ-007 src_row  in  10  source row to fetch, sampled only when line_start=1.
REQ-008 sram_req  out  1  read request to the SRAM arbiter.
REQ-009 sram_addr  out  20  read address {column[9:0], row[9:0]}.
REQ-010 sram_gnt  in  1  arbiter grant; a read issues on each cycle with sram_req=1 and sram_gnt=1.
REQ-011 sram_rdata  in  16  read data, valid exactly one cycle after the granting cycle.
REQ-012 pix_en  in  1  active-video qualifier from the VGA timing generator.
REQ-013 pix_x  in  10  VGA column 0..639.
REQ-014 vga_r, vga_g, vga_b  out  8 each  pixel color.
REQ-015 busy  out  1  high while a row fetch is in progress.
REQ-016 underrun  out  1  sticky flag: a line_start arrived before the pending fetch completed.

Function
REQ-017 Two line buffers of H_SRC x 12 bits (front = displayed, back = being filled) SHALL be held internally.
REQ-018 The fetch FSM SHALL have states IDLE, FETCH, DRAIN.
REQ-019 IDLE: sram_req=0; on a valid line_start, go to FETCH with col=0 and row=src_row.
REQ-020 FETCH: sram_req=1, sram_addr={col,row}; each granted cycle increments col; the grant of col=H_SRC-1 moves to DRAIN and drops sram_req the next cycle.
REQ-021 DRAIN: the final data is written on the cycle after the last grant; then go to IDLE and set ready=1.
REQ-022 Each returned word SHALL be stored at back[issued column] as sram_rdata[15:4]; no read is issued without sram_gnt.
REQ-023 busy SHALL be 1 exactly in FETCH and DRAIN.
REQ-024 line_start with ready=1: swap front/back, set front_valid=1, clear ready, start a fetch of src_row.
REQ-025 line_start with busy=1: set underrun, abort the fetch (data still in flight is discarded), do not swap, restart the fetch at col=0 for the new src_row.
REQ-026 line_start with busy=0 and ready=0: start a fetch with no swap and no underrun.
REQ-027 line_start on the same cycle as the final DRAIN write SHALL be treated as busy (REQ-025).
REQ-028 line_start with src_row >= V_SRC SHALL be ignored entirely: no swap, no fetch, no flag change.
REQ-029 Pixel path: vga_r/g/b one cycle after pix_x/pix_en = {front[pix_x>>1][11:8],4'h0}, {[7:4],4'h0}, {[3:0],4'h0}.
REQ-030 Pixel output SHALL be 0 when pix_en=0, pix_x>>1 >= H_SRC, or front_valid=0.
REQ-031 The pixel path SHALL never stall and SHALL be independent of fetch state.

Reset
REQ-032 rst SHALL force IDLE, sram_req=0, sram_addr=0, busy=0, underrun=0, ready=0, front_valid=0, and vga_r/g/b=0 on the following cycle.
REQ-033 rst during a fetch SHALL abort it; returning data is discarded and buffer contents are don't-care.

Verification
REQ-034 Continuous gnt=1, line_start src_row=5 -> addresses {0,5}..{319,5} on 320 consecutive cycles; busy drops 2 cycles after the last grant; ready=1.
REQ-035 Memory word = 0xABC0 at every column, two line_starts, then pix_en=1 with pix_x=0..639 -> every output pixel is r=0xA0, g=0xB0, b=0xC0 with 1-cycle latency; pix_x=0 and 1 both map to column 0.
REQ-036 gnt toggled 1/0 every cycle -> fetch takes 640 request cycles; no column skipped or duplicated in the back buffer.
REQ-037 Second line_start 100 cycles after the first -> underrun=1 (sticky), no swap, sram_addr restarts at {0,new_row}.
REQ-038 line_start with src_row=240 -> no request, state unchanged; rst mid-fetch -> sram_req=0 the next cycle, outputs 0.
